// File: rtl/rename_dispatch_group_pkg.sv
// rtl/rename_dispatch_group_pkg.sv - shared rename/dispatch types, widths and instruction classification
package rv32i_types;

    // Must agree with the PR_ENTRIES / ROB_DEPTH parameters of the rename stage.
    localparam int PRW = 6;
    localparam int RIW = 3;

    typedef enum logic [6:0] {
        OP_LUI    = 7'b0110111,
        OP_AUIPC  = 7'b0010111,
        OP_JAL    = 7'b1101111,
        OP_JALR   = 7'b1100111,
        OP_BRANCH = 7'b1100011,
        OP_LOAD   = 7'b0000011,
        OP_STORE  = 7'b0100011,
        OP_IMM    = 7'b0010011,
        OP_REG    = 7'b0110011,
        OP_FENCE  = 7'b0001111,
        OP_SYSTEM = 7'b1110011
    } rv_opcode_t;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        rv_opcode_t  opcode;
        logic [4:0]  rd_s;
        logic [4:0]  rs1_s;
        logic [4:0]  rs2_s;
        logic        rs1_used;   // 0 when the operand is an immediate / absent
        logic        rs2_used;
        logic [3:0]  wmask;      // non-zero marks a store
    } instruction_info_reg_t;

    typedef struct packed {
        logic [63:0] order;
        logic [31:0] inst;
        logic [31:0] pc_rdata;
        logic [4:0]  rs1_addr;
        logic [4:0]  rs2_addr;
        logic [4:0]  rd_addr;
        logic [3:0]  mem_wmask;
    } rvfi_t;

    typedef struct packed {
        logic [RIW-1:0] rob_id;
        logic           commit;
        rvfi_t          rvfi;
    } rob_entry_t;

    typedef struct packed {
        instruction_info_reg_t inst;
        logic [PRW-1:0]        rs1_p;
        logic [PRW-1:0]        rs2_p;
        logic [PRW-1:0]        rd_p;
        logic [RIW-1:0]        rs1_source;
        logic [RIW-1:0]        rs2_source;
        logic                  input1_met;
        logic                  input2_met;
    } rs_entry_t;

    typedef struct packed {
        rob_entry_t  rob;
        rs_entry_t   rs;
        logic [31:0] cross_entry;
    } super_dispatch_t;

    function automatic logic is_writer(input instruction_info_reg_t i);
        logic w;
        case (i.opcode)
            OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_LOAD, OP_IMM, OP_REG: w = 1'b1;
            default:                                                   w = 1'b0;
        endcase
        return w && (i.rd_s != 5'd0);
    endfunction

    function automatic logic is_store(input instruction_info_reg_t i);
        return |i.wmask;
    endfunction

endpackage

// File: rtl/rename_dispatch_group_dispatch_select.sv
// rtl/rename_dispatch_group_dispatch_select.sv - in-order prefix acceptance and free-list slot allocation
module dispatch_select #(
    parameter int SS         = 2,
    parameter int RCW        = 4,
    parameter int FCW        = 7,
    parameter int SCW        = 3,
    parameter int MAX_STORES = 4,
    localparam int CW        = $clog2(SS + 1),
    localparam int AW        = (SS > 1) ? $clog2(SS) : 1
) (
    input  logic            block,
    input  logic            inst_valid [SS],
    input  logic            writer     [SS],
    input  logic            store      [SS],
    input  logic [RCW-1:0]  rob_free,
    input  logic [RCW-1:0]  rs_free,
    input  logic [CW-1:0]   pend,
    input  logic [FCW-1:0]  free_count,
    input  logic [SCW-1:0]  store_cnt,
    output logic            accepted   [SS],
    output logic [AW-1:0]   alloc_idx  [SS],
    output logic [CW-1:0]   accept_count,
    output logic [CW-1:0]   writer_count,
    output logic [CW-1:0]   store_count
);

    always_comb begin
        int  nw;
        int  ns;
        int  na;
        logic ok;
        nw = 0;
        ns = 0;
        na = 0;
        ok = !block;
        for (int k = 0; k < SS; k++) begin
            // A slot's free-list index is the number of accepted writers ahead of it.
            alloc_idx[k] = AW'(nw);
            // Entries already in the stage register still need ROB/RS space.
            ok = ok && inst_valid[k]
                 && (k + 1 + int'(pend) <= int'(rob_free))
                 && (k + 1 + int'(pend) <= int'(rs_free))
                 && (nw + int'(writer[k]) <= int'(free_count))
                 && (ns + int'(store[k]) + int'(store_cnt) <= MAX_STORES);
            accepted[k] = ok;
            if (ok) begin
                nw = nw + int'(writer[k]);
                ns = ns + int'(store[k]);
                na = na + 1;
            end
        end
        accept_count = CW'(na);
        writer_count = CW'(nw);
        store_count  = CW'(ns);
    end

endmodule

// File: rtl/rename_dispatch_group.sv
// rtl/rename_dispatch_group.sv - SS-wide rename/dispatch stage with intra-group bypass and store limit
module rename_dispatch_group
    import rv32i_types::*;
#(
    parameter int SS         = 2,
    parameter int PR_ENTRIES = 64,
    parameter int ROB_DEPTH  = 8,
    parameter int MAX_STORES = 4,
    localparam int CW        = $clog2(SS + 1),
    localparam int FCW       = $clog2(PR_ENTRIES + 1),
    localparam int RCW       = $clog2(ROB_DEPTH + 1),
    localparam int SCW       = $clog2(MAX_STORES + 1),
    localparam int AW        = (SS > 1) ? $clog2(SS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  inst_valid     [SS],
    input  instruction_info_reg_t inst           [SS],
    output logic [CW-1:0]         inst_pop_count,
    output logic [4:0]            isa_rs1        [SS],
    output logic [4:0]            isa_rs2        [SS],
    input  logic [PRW-1:0]        rat_rs1        [SS],
    input  logic [PRW-1:0]        rat_rs2        [SS],
    output logic                  rat_we         [SS],
    output logic [4:0]            isa_rd         [SS],
    output logic [PRW-1:0]        rat_rd         [SS],
    input  logic [PRW-1:0]        free_rat_rds   [SS],
    input  logic [FCW-1:0]        free_count,
    output logic [CW-1:0]         free_pop_count,
    input  logic [PR_ENTRIES-1:0] pr_busy,
    input  logic                  cdb_valid,
    input  logic [PRW-1:0]        cdb_pr,
    input  logic [RIW-1:0]        rob_id_next    [SS],
    input  logic [RCW-1:0]        rob_free,
    input  logic [RCW-1:0]        rs_free,
    input  logic                  store_commit,
    output logic                  dispatch_valid [SS],
    output super_dispatch_t       rs_rob_entry   [SS]
);

    logic            writer [SS];
    logic            store  [SS];
    logic            accepted [SS];
    logic [AW-1:0]   alloc_idx [SS];
    logic [CW-1:0]   pend;
    logic [CW-1:0]   accept_count;
    logic [CW-1:0]   writer_count;
    logic [CW-1:0]   store_count;

    logic            dispatch_valid_q [SS];
    logic            dispatch_valid_d [SS];
    super_dispatch_t entry_q [SS];
    super_dispatch_t entry_d [SS];
    logic [SCW-1:0]  store_cnt_q;
    logic [SCW-1:0]  store_cnt_d;

    always_comb begin
        pend = '0;
        for (int k = 0; k < SS; k++) begin
            writer[k] = is_writer(inst[k]);
            store[k]  = is_store(inst[k]);
            pend      = pend + CW'(dispatch_valid_q[k]);
        end
    end

    // Reset is folded into the block input so every pop/write output is zero under rst.
    dispatch_select #(
        .SS         (SS),
        .RCW        (RCW),
        .FCW        (FCW),
        .SCW        (SCW),
        .MAX_STORES (MAX_STORES)
    ) u_select (
        .block        (rst || flush),
        .inst_valid   (inst_valid),
        .writer       (writer),
        .store        (store),
        .rob_free     (rob_free),
        .rs_free      (rs_free),
        .pend         (pend),
        .free_count   (free_count),
        .store_cnt    (store_cnt_q),
        .accepted     (accepted),
        .alloc_idx    (alloc_idx),
        .accept_count (accept_count),
        .writer_count (writer_count),
        .store_count  (store_count)
    );

    always_comb begin
        inst_pop_count = accept_count;
        free_pop_count = writer_count;
        for (int k = 0; k < SS; k++) begin
            isa_rs1[k] = rst ? 5'd0 : inst[k].rs1_s;
            isa_rs2[k] = rst ? 5'd0 : inst[k].rs2_s;
            isa_rd[k]  = rst ? 5'd0 : inst[k].rd_s;
            rat_we[k]  = accepted[k] && writer[k];
            // Non-writers get mapping 0 so x0 never consumes a free register.
            rat_rd[k]  = rat_we[k] ? free_rat_rds[alloc_idx[k]] : '0;
        end
    end

    always_comb begin
        logic [PRW-1:0] p1, p2;
        logic [RIW-1:0] s1, s2;
        logic           b1, b2, m1, m2;
        p1 = '0; p2 = '0; s1 = '0; s2 = '0;
        b1 = 1'b0; b2 = 1'b0; m1 = 1'b0; m2 = 1'b0;
        for (int j = 0; j < SS; j++) begin
            p1 = rat_rs1[j];
            p2 = rat_rs2[j];
            s1 = '0;
            s2 = '0;
            b1 = 1'b0;
            b2 = 1'b0;
            // Ascending scan: the youngest older writer of the same register wins.
            for (int i = 0; i < SS; i++) begin
                if (i < j && rat_we[i]) begin
                    if (inst[i].rd_s == inst[j].rs1_s) begin
                        p1 = rat_rd[i];
                        s1 = rob_id_next[i];
                        b1 = 1'b1;
                    end
                    if (inst[i].rd_s == inst[j].rs2_s) begin
                        p2 = rat_rd[i];
                        s2 = rob_id_next[i];
                        b2 = 1'b1;
                    end
                end
            end
            // The CDB broadcast lands this cycle, so its register is already ready.
            m1 = !inst[j].rs1_used || (inst[j].rs1_s == 5'd0)
                 || (!b1 && (!pr_busy[p1] || (cdb_valid && (cdb_pr == p1))));
            m2 = !inst[j].rs2_used || (inst[j].rs2_s == 5'd0)
                 || (!b2 && (!pr_busy[p2] || (cdb_valid && (cdb_pr == p2))));

            entry_d[j]                    = '0;
            entry_d[j].cross_entry        = 'x;
            entry_d[j].rob.rob_id         = rob_id_next[j];
            entry_d[j].rob.commit         = 1'b0;
            entry_d[j].rob.rvfi.inst      = inst[j].inst;
            entry_d[j].rob.rvfi.pc_rdata  = inst[j].pc;
            entry_d[j].rob.rvfi.rs1_addr  = inst[j].rs1_used ? inst[j].rs1_s : 5'd0;
            entry_d[j].rob.rvfi.rs2_addr  = inst[j].rs2_used ? inst[j].rs2_s : 5'd0;
            entry_d[j].rob.rvfi.rd_addr   = writer[j] ? inst[j].rd_s : 5'd0;
            entry_d[j].rob.rvfi.mem_wmask = inst[j].wmask;
            entry_d[j].rs.inst            = inst[j];
            entry_d[j].rs.rs1_p           = p1;
            entry_d[j].rs.rs2_p           = p2;
            entry_d[j].rs.rd_p            = rat_rd[j];
            entry_d[j].rs.rs1_source      = s1;
            entry_d[j].rs.rs2_source      = s2;
            entry_d[j].rs.input1_met      = m1;
            entry_d[j].rs.input2_met      = m2;

            dispatch_valid_d[j] = accepted[j];
        end
    end

    always_comb begin
        if (flush) begin
            store_cnt_d = '0;
        end else begin
            store_cnt_d = store_cnt_q + SCW'(store_count)
                          - SCW'(store_commit && (store_cnt_q != '0));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < SS; k++) begin
                dispatch_valid_q[k] <= 1'b0;
                entry_q[k]          <= 'x;
            end
            store_cnt_q <= '0;
        end else begin
            for (int k = 0; k < SS; k++) begin
                dispatch_valid_q[k] <= dispatch_valid_d[k];
                entry_q[k]          <= entry_d[k];
            end
            store_cnt_q <= store_cnt_d;
        end
    end

    always_comb begin
        for (int k = 0; k < SS; k++) begin
            dispatch_valid[k] = dispatch_valid_q[k];
            rs_rob_entry[k]   = entry_q[k];
        end
    end

endmodule

// File: tb/tb_rename_dispatch_group.sv
// tb/tb_rename_dispatch_group.sv - directed scoreboard bench for rename_dispatch_group
module tb_rename_dispatch_group;
    import rv32i_types::*;

    localparam int SS  = 2;
    localparam int PR  = 64;
    localparam int RD  = 8;
    localparam int MS  = 2;
    localparam int CW  = $clog2(SS + 1);
    localparam int FCW = $clog2(PR + 1);
    localparam int RCW = $clog2(RD + 1);

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  flush;
    logic                  inst_valid [SS];
    instruction_info_reg_t inst [SS];
    logic [CW-1:0]         inst_pop_count;
    logic [4:0]            isa_rs1 [SS];
    logic [4:0]            isa_rs2 [SS];
    logic [PRW-1:0]        rat_rs1 [SS];
    logic [PRW-1:0]        rat_rs2 [SS];
    logic                  rat_we [SS];
    logic [4:0]            isa_rd [SS];
    logic [PRW-1:0]        rat_rd [SS];
    logic [PRW-1:0]        free_rat_rds [SS];
    logic [FCW-1:0]        free_count;
    logic [CW-1:0]         free_pop_count;
    logic [PR-1:0]         pr_busy;
    logic                  cdb_valid;
    logic [PRW-1:0]        cdb_pr;
    logic [RIW-1:0]        rob_id_next [SS];
    logic [RCW-1:0]        rob_free;
    logic [RCW-1:0]        rs_free;
    logic                  store_commit;
    logic                  dispatch_valid [SS];
    super_dispatch_t       rs_rob_entry [SS];

    rename_dispatch_group #(
        .SS(SS), .PR_ENTRIES(PR), .ROB_DEPTH(RD), .MAX_STORES(MS)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .inst_valid(inst_valid), .inst(inst), .inst_pop_count(inst_pop_count),
        .isa_rs1(isa_rs1), .isa_rs2(isa_rs2), .rat_rs1(rat_rs1), .rat_rs2(rat_rs2),
        .rat_we(rat_we), .isa_rd(isa_rd), .rat_rd(rat_rd),
        .free_rat_rds(free_rat_rds), .free_count(free_count), .free_pop_count(free_pop_count),
        .pr_busy(pr_busy), .cdb_valid(cdb_valid), .cdb_pr(cdb_pr),
        .rob_id_next(rob_id_next), .rob_free(rob_free), .rs_free(rs_free),
        .store_commit(store_commit),
        .dispatch_valid(dispatch_valid), .rs_rob_entry(rs_rob_entry)
    );

    always #5 clk = ~clk;

    typedef struct {
        int             slot;
        logic [RIW-1:0] rob_id;
        logic [PRW-1:0] rs1_p;
        logic [PRW-1:0] rs2_p;
        logic [PRW-1:0] rd_p;
        logic [RIW-1:0] rs1_src;
        logic           met1;
        logic           met2;
    } exp_t;

    exp_t     exp_q[$];
    logic [1:0] exp_mask;
    int       n_checks = 0;
    int       n_errors = 0;

    function automatic instruction_info_reg_t mk(input rv_opcode_t op, input logic [4:0] rd,
                                                 input logic [4:0] r1, input logic [4:0] r2,
                                                 input logic u1, input logic u2,
                                                 input logic [3:0] wm);
        instruction_info_reg_t i;
        i          = '0;
        i.opcode   = op;
        i.rd_s     = rd;
        i.rs1_s    = r1;
        i.rs2_s    = r2;
        i.rs1_used = u1;
        i.rs2_used = u2;
        i.wmask    = wm;
        i.inst     = {7'd0, r2, r1, 3'd0, rd, op};
        i.pc       = 32'h100;
        return i;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic push(input int slot, input int rob, input int r1, input int r2,
                        input int rd, input int src1, input logic m1, input logic m2);
        exp_t e;
        e.slot    = slot;
        e.rob_id  = RIW'(rob);
        e.rs1_p   = PRW'(r1);
        e.rs2_p   = PRW'(r2);
        e.rd_p    = PRW'(rd);
        e.rs1_src = RIW'(src1);
        e.met1    = m1;
        e.met2    = m2;
        exp_q.push_back(e);
    endtask

    task automatic sb_check();
        exp_t e;
        chk("dispatch_valid0", 64'(dispatch_valid[0]), 64'(exp_mask[0]));
        chk("dispatch_valid1", 64'(dispatch_valid[1]), 64'(exp_mask[1]));
        for (int k = 0; k < SS; k++) begin
            if (dispatch_valid[k]) begin
                n_checks++;
                assert (exp_q.size() > 0) else begin
                    n_errors++;
                    $error("FAIL sb_underflow observed=slot%0d expected=none", k);
                end
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("sb_slot",    64'(k), 64'(e.slot));
                    chk("rob_id",     64'(rs_rob_entry[k].rob.rob_id), 64'(e.rob_id));
                    chk("commit",     64'(rs_rob_entry[k].rob.commit), 64'(1'b0));
                    chk("rs1_p",      64'(rs_rob_entry[k].rs.rs1_p), 64'(e.rs1_p));
                    chk("rs2_p",      64'(rs_rob_entry[k].rs.rs2_p), 64'(e.rs2_p));
                    chk("rd_p",       64'(rs_rob_entry[k].rs.rd_p), 64'(e.rd_p));
                    chk("rs1_source", 64'(rs_rob_entry[k].rs.rs1_source), 64'(e.rs1_src));
                    chk("input1_met", 64'(rs_rob_entry[k].rs.input1_met), 64'(e.met1));
                    chk("input2_met", 64'(rs_rob_entry[k].rs.input2_met), 64'(e.met2));
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
        sb_check();
    endtask

    task automatic set_group(input instruction_info_reg_t a, input logic va,
                             input instruction_info_reg_t b, input logic vb);
        inst[0]       = a;
        inst[1]       = b;
        inst_valid[0] = va;
        inst_valid[1] = vb;
    endtask

    task automatic comb(input int pop, input int fpop, input logic we0, input logic we1);
        #2;
        chk("inst_pop_count", 64'(inst_pop_count), 64'(pop));
        chk("free_pop_count", 64'(free_pop_count), 64'(fpop));
        chk("rat_we0", 64'(rat_we[0]), 64'(we0));
        chk("rat_we1", 64'(rat_we[1]), 64'(we1));
    endtask

    instruction_info_reg_t add5, sub6, sw_i, addi0, add7, add8, add9;

    initial begin
        add5  = mk(OP_REG,   5'd5, 5'd1, 5'd2, 1'b1, 1'b1, 4'h0);
        sub6  = mk(OP_REG,   5'd6, 5'd5, 5'd3, 1'b1, 1'b1, 4'h0);
        sw_i  = mk(OP_STORE, 5'd0, 5'd1, 5'd2, 1'b1, 1'b1, 4'hf);
        addi0 = mk(OP_IMM,   5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 4'h0);
        add7  = mk(OP_REG,   5'd7, 5'd1, 5'd2, 1'b1, 1'b1, 4'h0);
        add8  = mk(OP_REG,   5'd8, 5'd1, 5'd2, 1'b1, 1'b1, 4'h0);
        add9  = mk(OP_REG,   5'd9, 5'd1, 5'd2, 1'b1, 1'b1, 4'h0);

        rst = 1'b1; flush = 1'b0; store_commit = 1'b0;
        rat_rs1[0] = 6'd10; rat_rs1[1] = 6'd11;
        rat_rs2[0] = 6'd12; rat_rs2[1] = 6'd13;
        free_rat_rds[0] = 6'd40; free_rat_rds[1] = 6'd41;
        rob_id_next[0] = 3'd3; rob_id_next[1] = 3'd4;
        free_count = FCW'(64); rob_free = RCW'(8); rs_free = RCW'(8);
        pr_busy = '0; cdb_valid = 1'b0; cdb_pr = '0;
        set_group(add5, 1'b1, sub6, 1'b1);
        exp_mask = 2'b00;

        // Reset: nothing pops, RAT addresses are held at zero.
        comb(0, 0, 1'b0, 1'b0);
        chk("rst_isa_rs1", 64'(isa_rs1[0]), 64'(0));
        tick();
        chk("rst_store_cnt", 64'(dut.store_cnt_q), 64'(0));
        rst = 1'b0;

        // add x5 / sub x6 using x5: intra-group bypass.
        comb(2, 2, 1'b1, 1'b1);
        chk("rat_rd0", 64'(rat_rd[0]), 64'(40));
        chk("rat_rd1", 64'(rat_rd[1]), 64'(41));
        chk("isa_rs1_1", 64'(isa_rs1[1]), 64'(5));
        chk("isa_rd1", 64'(isa_rd[1]), 64'(6));
        push(0, 3, 10, 12, 40, 0, 1'b1, 1'b1);
        push(1, 4, 40, 13, 41, 3, 1'b0, 1'b1);
        exp_mask = 2'b11;
        tick();

        // sw / addi x0: no free-list pops, one store counted.
        set_group(sw_i, 1'b1, addi0, 1'b1);
        comb(2, 0, 1'b0, 1'b0);
        chk("x0_rat_rd1", 64'(rat_rd[1]), 64'(0));
        push(0, 3, 10, 12, 0, 0, 1'b1, 1'b1);
        push(1, 4, 11, 13, 0, 0, 1'b1, 1'b1);
        exp_mask = 2'b11;
        tick();
        chk("store_cnt_1", 64'(dut.store_cnt_q), 64'(1));

        // Idle cycle drains the stage register so pend returns to 0.
        set_group(add7, 1'b0, add8, 1'b0);
        comb(0, 0, 1'b0, 1'b0);
        exp_mask = 2'b00;
        tick();

        // ROB limit of one entry, then the pending entry blocks the next group.
        rob_free = RCW'(1); rs_free = RCW'(4);
        set_group(add7, 1'b1, add8, 1'b1);
        comb(1, 1, 1'b1, 1'b0);
        push(0, 3, 10, 12, 40, 0, 1'b1, 1'b1);
        exp_mask = 2'b01;
        tick();
        comb(0, 0, 1'b0, 1'b0);
        exp_mask = 2'b00;
        tick();

        // RS limit of one entry with nothing pending.
        rob_free = RCW'(8); rs_free = RCW'(1);
        comb(1, 1, 1'b1, 1'b0);
        push(0, 3, 10, 12, 40, 0, 1'b1, 1'b1);
        exp_mask = 2'b01;
        tick();
        rs_free = RCW'(8);

        // Store limit: counter 1 of 2 allows only one of two stores.
        set_group(sw_i, 1'b1, sw_i, 1'b1);
        comb(1, 0, 1'b0, 1'b0);
        push(0, 3, 10, 12, 0, 0, 1'b1, 1'b1);
        exp_mask = 2'b01;
        tick();
        chk("store_cnt_2", 64'(dut.store_cnt_q), 64'(2));

        // Counter full: stall, while a store commit frees a slot.
        set_group(sw_i, 1'b1, add9, 1'b1);
        store_commit = 1'b1;
        comb(0, 0, 1'b0, 1'b0);
        exp_mask = 2'b00;
        tick();
        chk("store_cnt_after_commit", 64'(dut.store_cnt_q), 64'(1));
        store_commit = 1'b0;

        // Writer in slot1 behind a store takes the first free entry.
        comb(2, 1, 1'b0, 1'b1);
        chk("alloc_rat_rd1", 64'(rat_rd[1]), 64'(40));
        push(0, 3, 10, 12, 0, 0, 1'b1, 1'b1);
        push(1, 4, 11, 13, 40, 0, 1'b1, 1'b1);
        exp_mask = 2'b11;
        tick();
        chk("store_cnt_2b", 64'(dut.store_cnt_q), 64'(2));

        // Only one free register.
        free_count = FCW'(1);
        set_group(add7, 1'b1, add8, 1'b1);
        comb(1, 1, 1'b1, 1'b0);
        push(0, 3, 10, 12, 40, 0, 1'b1, 1'b1);
        exp_mask = 2'b01;
        tick();

        // Flush with a full valid group.
        free_count = FCW'(64);
        flush = 1'b1;
        comb(0, 0, 1'b0, 1'b0);
        exp_mask = 2'b00;
        tick();
        chk("flush_store_cnt", 64'(dut.store_cnt_q), 64'(0));
        flush = 1'b0;

        // Busy source woken by the CDB this cycle; the other source stays busy.
        pr_busy[10] = 1'b1;
        pr_busy[12] = 1'b1;
        cdb_valid = 1'b1;
        cdb_pr = 6'd10;
        set_group(add5, 1'b1, sub6, 1'b0);
        comb(1, 1, 1'b1, 1'b0);
        push(0, 3, 10, 12, 40, 0, 1'b1, 1'b0);
        exp_mask = 2'b01;
        tick();

        cdb_valid = 1'b0;
        set_group(add5, 1'b0, sub6, 1'b0);
        exp_mask = 2'b00;
        tick();
        chk("sb_drain", 64'(exp_q.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
